// File: rtl/bmp_op_seq_if.sv
// Bitmap op sequencer bus bundle.
//   req_*   : decode -> sequencer op request (valid/ready handshake)
//   dp_ready: bitmap datapath accepts the issued chunk this cycle
//   rd_*, dp_op, dp_amt : chunk issue towards the bitmap datapath
//   wr_*    : registered writeback strobe, destination and chunk index
// The slave modport is the sequencer; master is the decode/datapath side.
interface bmp_op_seq_if #(
  parameter int IDX_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [1:0]       req_bs;
  logic [1:0]       req_bd;
  logic [3:0]       req_amt;
  logic             dp_ready;
  logic             rd_en;
  logic [1:0]       rd_bs;
  logic [IDX_W-1:0] rd_idx;
  logic [1:0]       dp_op;
  logic [3:0]       dp_amt;
  logic             wr_en;
  logic [1:0]       wr_bd;
  logic [IDX_W-1:0] wr_idx;

  modport slave (
    input  req_valid, req_op, req_bs, req_bd, req_amt, dp_ready,
    output req_ready, rd_en, rd_bs, rd_idx, dp_op, dp_amt, wr_en, wr_bd, wr_idx
  );

  modport master (
    output req_valid, req_op, req_bs, req_bd, req_amt, dp_ready,
    input  req_ready, rd_en, rd_bs, rd_idx, dp_op, dp_amt, wr_en, wr_bd, wr_idx
  );
endinterface

// File: rtl/bmp_op_seq.sv
// Multi-cycle sequencer for bitmap-register ops (move, bsh shift, bsl scale).
// Accepts one op from decode, then issues one chunk per cycle to the bitmap
// datapath and produces a one-cycle-delayed writeback strobe per accepted
// chunk. The upstream pipeline is stalled while the op is in flight.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : request / issue / writeback bundle (bmp_op_seq_if.slave)
//   flush    : abort the current op (branch taken)
//   stall    : hold upstream pipeline
//   busy     : op in progress
//   done     : one-cycle completion pulse
//   err      : sticky, reserved op seen since reset
module bmp_op_seq #(
  parameter int CHUNK_W    = 128,
  parameter int NUM_CHUNKS = 12,
  parameter int IDX_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  bmp_op_seq_if.slave bus,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic        err
);

  if ((1 << IDX_W) < NUM_CHUNKS || CHUNK_W < 1) begin : g_bad_geometry
    $error("bmp_op_seq: IDX_W too narrow for NUM_CHUNKS or CHUNK_W invalid");
  end

  typedef enum logic [1:0] {IDLE, RUN, WB, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_ASC = IDX_W'(NUM_CHUNKS - 1);

  state_t           state_reg, state_next;
  logic [1:0]       op_reg, bs_reg, bd_reg;
  logic [3:0]       amt_reg;
  logic             desc_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             wr_en_reg;
  logic [IDX_W-1:0] wr_idx_reg;
  logic             err_reg;

  logic accept, reserved, issue, last_idx, rd_en_c, req_ready_c;

  // Flush in IDLE blocks the accept; a reserved op only flags err.
  assign reserved = (state_reg == IDLE) && bus.req_valid && (bus.req_op == 2'b11);
  assign accept   = (state_reg == IDLE) && bus.req_valid && !flush && (bus.req_op != 2'b11);
  assign issue    = rd_en_c && bus.dp_ready;
  assign last_idx = desc_reg ? (idx_reg == '0) : (idx_reg == LAST_ASC);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = RUN;
      RUN: begin
        if (flush)                  state_next = IDLE;
        else if (issue && last_idx) state_next = WB;
      end
      WB:      state_next = flush ? IDLE : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic. stall/busy rise combinationally on the accept cycle so
  // decode is frozen while the op is being latched.
  always_comb begin
    req_ready_c = 1'b0;
    stall       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    rd_en_c     = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready_c = 1'b1;
        stall       = accept;
        busy        = accept;
      end
      RUN: begin
        stall   = 1'b1;
        busy    = 1'b1;
        rd_en_c = !flush;   // flush wins over dp_ready: nothing more issues
      end
      WB: begin
        stall = 1'b1;
        busy  = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Op latches, chunk index and writeback pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg     <= '0;
      bs_reg     <= '0;
      bd_reg     <= '0;
      amt_reg    <= '0;
      desc_reg   <= 1'b0;
      idx_reg    <= '0;
      wr_en_reg  <= 1'b0;
      wr_idx_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (accept) begin
        op_reg  <= bus.req_op;
        bs_reg  <= bus.req_bs;
        bd_reg  <= bus.req_bd;
        amt_reg <= bus.req_amt;
        // In-place shift walks from the top chunk down so that no source
        // chunk is overwritten before it has been read.
        desc_reg <= (bus.req_op == 2'b01) && (bus.req_bs == bus.req_bd);
        idx_reg  <= ((bus.req_op == 2'b01) && (bus.req_bs == bus.req_bd)) ? LAST_ASC : '0;
      end else if (issue && !last_idx) begin
        idx_reg <= desc_reg ? idx_reg - IDX_W'(1) : idx_reg + IDX_W'(1);
      end
      wr_en_reg  <= issue;
      wr_idx_reg <= issue ? idx_reg : '0;
      if (reserved) err_reg <= 1'b1;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rd_en     = rd_en_c;
  assign bus.rd_idx    = (state_reg == RUN) ? idx_reg : '0;
  assign bus.rd_bs     = (state_reg == RUN) ? bs_reg  : '0;
  assign bus.dp_op     = (state_reg == RUN) ? op_reg  : '0;
  assign bus.dp_amt    = (state_reg == RUN) ? amt_reg : '0;
  assign bus.wr_en     = wr_en_reg;
  assign bus.wr_idx    = wr_idx_reg;
  assign bus.wr_bd     = wr_en_reg ? bd_reg : '0;
  assign err           = err_reg;

endmodule

// File: tb/tb_bmp_op_seq.sv
// Directed self-checking bench for bmp_op_seq. Inputs change 1 time unit
// after each rising edge; outputs are checked 1 unit later.
module tb_bmp_op_seq;
  logic clk = 1'b0;
  logic rst, flush, stall, busy, done, err;
  int   checks = 0;
  int   errors = 0;
  int   wcnt;

  bmp_op_seq_if #(.IDX_W(4)) bus ();

  bmp_op_seq #(.CHUNK_W(128), .NUM_CHUNKS(12), .IDX_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .flush (flush),
    .stall (stall),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [1:0] op, input logic [1:0] bs,
                         input logic [1:0] bd, input logic [3:0] amt);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_bs    = bs;
    bus.req_bd    = bd;
    bus.req_amt   = amt;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_bs = '0;
    bus.req_bd = '0; bus.req_amt = '0; bus.dp_ready = 1'b1;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst req_ready", bus.req_ready, 1);
    chk("rst stall", stall, 0);
    chk("rst busy", busy, 0);
    chk("rst rd_en", bus.rd_en, 0);
    chk("rst wr_en", bus.wr_en, 0);
    chk("rst err", err, 0);
    $display("reset done");

    // Move op 00, bs=1, bd=2
    tick();
    request(2'b00, 2'd1, 2'd2, 4'd0);
    #1;
    chk("move c0 stall", stall, 1);
    chk("move c0 busy", busy, 1);
    for (int c = 1; c <= 15; c++) begin
      tick();
      bus.req_valid = 1'b0;
      #1;
      chk($sformatf("move c%0d rd_en", c), bus.rd_en, (c <= 12));
      chk($sformatf("move c%0d rd_idx", c), bus.rd_idx, (c <= 12) ? c - 1 : 0);
      chk($sformatf("move c%0d rd_bs", c), bus.rd_bs, (c <= 12) ? 1 : 0);
      chk($sformatf("move c%0d wr_en", c), bus.wr_en, (c >= 2 && c <= 13));
      chk($sformatf("move c%0d wr_idx", c), bus.wr_idx, (c >= 2 && c <= 13) ? c - 2 : 0);
      chk($sformatf("move c%0d wr_bd", c), bus.wr_bd, (c >= 2 && c <= 13) ? 2 : 0);
      chk($sformatf("move c%0d done", c), done, (c == 14));
      chk($sformatf("move c%0d stall", c), stall, (c <= 13));
      chk($sformatf("move c%0d req_ready", c), bus.req_ready, (c == 15));
    end
    $display("move op complete");

    // In-place shift: descending walk
    tick();
    request(2'b01, 2'd3, 2'd3, 4'd4);
    #1;
    wcnt = 0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      bus.req_valid = 1'b0;
      #1;
      chk($sformatf("shift c%0d rd_en", c), bus.rd_en, (c <= 12));
      chk($sformatf("shift c%0d rd_idx", c), bus.rd_idx, (c <= 12) ? 12 - c : 0);
      chk($sformatf("shift c%0d dp_op", c), bus.dp_op, (c <= 12) ? 1 : 0);
      chk($sformatf("shift c%0d dp_amt", c), bus.dp_amt, (c <= 12) ? 4 : 0);
      chk($sformatf("shift c%0d wr_idx", c), bus.wr_idx, (c >= 2 && c <= 13) ? 13 - c : 0);
      chk($sformatf("shift c%0d done", c), done, (c == 14));
      if (bus.wr_en) wcnt++;
    end
    chk("shift wr_en count", wcnt, 12);
    $display("in-place shift complete");

    // dp_ready low for 3 cycles while rd_idx=5
    tick();
    request(2'b00, 2'd0, 2'd1, 4'd0);
    #1;
    wcnt = 0;
    for (int c = 1; c <= 18; c++) begin
      tick();
      bus.req_valid = 1'b0;
      bus.dp_ready  = !(c >= 6 && c <= 8);
      #1;
      chk($sformatf("bp c%0d rd_en", c), bus.rd_en, (c <= 15));
      chk($sformatf("bp c%0d rd_idx", c), bus.rd_idx,
          (c <= 6) ? c - 1 : (c <= 8) ? 5 : (c <= 15) ? c - 4 : 0);
      chk($sformatf("bp c%0d wr_en", c), bus.wr_en, ((c >= 2 && c <= 6) || (c >= 10 && c <= 16)));
      chk($sformatf("bp c%0d wr_idx", c), bus.wr_idx,
          (c >= 2 && c <= 6) ? c - 2 : (c >= 10 && c <= 16) ? c - 5 : 0);
      chk($sformatf("bp c%0d done", c), done, (c == 17));
      chk($sformatf("bp c%0d stall", c), stall, (c <= 16));
      if (bus.wr_en) wcnt++;
    end
    chk("bp wr_en count", wcnt, 12);
    bus.dp_ready = 1'b1;
    $display("backpressure op complete");

    // Flush the cycle after idx 7 is accepted
    tick();
    request(2'b10, 2'd2, 2'd0, 4'd3);
    #1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      bus.req_valid = 1'b0;
      #1;
    end
    chk("flush pre rd_idx", bus.rd_idx, 7);
    tick();
    flush = 1'b1;
    #1;
    chk("flush c9 rd_en", bus.rd_en, 0);
    chk("flush c9 wr_en", bus.wr_en, 1);
    chk("flush c9 wr_idx", bus.wr_idx, 7);
    tick();
    flush = 1'b0;
    #1;
    chk("flush c10 req_ready", bus.req_ready, 1);
    chk("flush c10 wr_en", bus.wr_en, 0);
    chk("flush c10 stall", stall, 0);
    for (int c = 10; c <= 13; c++) begin
      if (c > 10) tick();
      #1;
      chk($sformatf("flush c%0d rd_en", c), bus.rd_en, 0);
      chk($sformatf("flush c%0d done", c), done, 0);
    end
    $display("flush op complete");

    // Reserved op sets sticky err
    tick();
    request(2'b11, 2'd1, 2'd1, 4'd0);
    #1;
    chk("rsv stall", stall, 0);
    chk("rsv busy", busy, 0);
    chk("rsv req_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    #1;
    chk("rsv err", err, 1);
    chk("rsv req_ready after", bus.req_ready, 1);
    chk("rsv rd_en after", bus.rd_en, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rsv err cleared", err, 0);
    $display("reserved op checked");

    // Reset mid-RUN at rd_idx=4
    tick();
    request(2'b00, 2'd1, 2'd2, 4'd0);
    #1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      bus.req_valid = 1'b0;
      #1;
    end
    chk("midrst rd_idx", bus.rd_idx, 4);
    chk("midrst rd_en", bus.rd_en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst rd_en after", bus.rd_en, 0);
    chk("midrst rd_idx after", bus.rd_idx, 0);
    chk("midrst wr_en after", bus.wr_en, 0);
    chk("midrst wr_idx after", bus.wr_idx, 0);
    chk("midrst req_ready", bus.req_ready, 1);
    chk("midrst stall", stall, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    for (int c = 7; c <= 9; c++) begin
      tick();
      #1;
      chk($sformatf("midrst c%0d wr_en", c), bus.wr_en, 0);
      chk($sformatf("midrst c%0d rd_en", c), bus.rd_en, 0);
    end
    $display("mid-run reset checked");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
